// File: rtl/uart_tx_arbiter_if.sv
// uart_tx_arbiter_if
//   Bundles the requester handshake, the arbiter status outputs and the
//   uart_TX launch/feedback signals that connect to uart_tx_arbiter.
// Parameters
//   NUM_REQ      number of byte sources (1..16)
// Signals
//   req_valid    [NUM_REQ]    per-requester byte valid
//   req_data     [8*NUM_REQ]  requester i byte at [8*i+7:8*i]
//   req_ready    [NUM_REQ]    one-cycle one-hot accept pulse
//   grant_id     [IDW]        index of current/last winner
//   busy                      arbiter is not idle
//   err_timeout               one-cycle pulse when the watchdog aborts a frame
//   tx_data      [8]          byte to uart_TX dataTX
//   tx_valid                  one-cycle launch pulse to uart_TX dataTXValid
//   tx_active                 uart_TX activeTX status
//   tx_done                   uart_TX doneTX pulse at the end of the stop bit
// Modports
//   master  client/uart side: drives requests and uart_TX feedback
//   slave   the arbiter itself
interface uart_tx_arbiter_if #(
  parameter int NUM_REQ = 4
);
  localparam int IDW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  logic [NUM_REQ-1:0]   req_valid;
  logic [8*NUM_REQ-1:0] req_data;
  logic [NUM_REQ-1:0]   req_ready;
  logic [IDW-1:0]       grant_id;
  logic                 busy;
  logic                 err_timeout;
  logic [7:0]           tx_data;
  logic                 tx_valid;
  logic                 tx_active;
  logic                 tx_done;

  modport master (
    output req_valid, req_data, tx_active, tx_done,
    input  req_ready, grant_id, busy, err_timeout, tx_data, tx_valid
  );

  modport slave (
    input  req_valid, req_data, tx_active, tx_done,
    output req_ready, grant_id, busy, err_timeout, tx_data, tx_valid
  );
endinterface

// File: rtl/uart_tx_arbiter.sv
// uart_tx_arbiter
//   Shares one uart_TX instance between NUM_REQ byte sources using strict
//   round-robin arbitration. A granted byte is launched on tx_data/tx_valid,
//   the arbiter then waits for tx_done (guarded by a watchdog), spends one
//   guard cycle so uart_TX can settle, and returns to idle.
// Parameters
//   NUM_REQ       number of requesters, 1..16
//   CLKS_PER_BIT  uart_TX bit period in clk cycles
//   TIMEOUT_CLKS  max cycles spent waiting for tx_done before abort
// Ports
//   clk           system clock, rising edge
//   rst           asynchronous active-high reset
//   bus           uart_tx_arbiter_if.slave (requests, status, uart_TX link)
// Optional feature
//   UART_ARB_ID_HDR_EN  when defined, every granted byte is preceded by a
//                       header byte {4'hA, grant_id zero-padded to 4 bits};
//                       req_ready is only issued with the data frame.
//                       Undefined (default): one data frame per grant.
module uart_tx_arbiter #(
  parameter int NUM_REQ      = 4,
  parameter int CLKS_PER_BIT = 87,
  parameter int TIMEOUT_CLKS = 12 * CLKS_PER_BIT
) (
  input logic              clk,
  input logic              rst,
  uart_tx_arbiter_if.slave bus
);

  localparam int IDW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  // A watchdog shorter than one full 10-bit frame plus handshake slack would
  // abort healthy frames, so the limit never drops below that floor.
  localparam int MIN_TIMEOUT = 10 * CLKS_PER_BIT + 2;
  localparam int WD_LIMIT    = (TIMEOUT_CLKS < MIN_TIMEOUT) ? MIN_TIMEOUT : TIMEOUT_CLKS;
  localparam int WDW         = $clog2(WD_LIMIT);
  localparam logic [WDW-1:0] WD_LAST = WDW'(WD_LIMIT - 1);

  typedef enum logic [2:0] {
    IDLE,
    LOAD,
    WAIT,
`ifdef UART_ARB_ID_HDR_EN
    HWAIT,
    HGUARD,
    DLOAD,
`endif
    GUARD
  } state_t;

  state_t               state;
  state_t               state_next;
  logic [IDW-1:0]       rr_ptr;
  logic [IDW-1:0]       rr_ptr_next;
  logic [IDW-1:0]       grant_id_q;
  logic [IDW-1:0]       grant_id_next;
  logic [WDW-1:0]       wd_cnt;
  logic [WDW-1:0]       wd_next;
  logic [7:0]           tx_data_q;
  logic [7:0]           tx_data_next;
  logic                 tx_valid_q;
  logic                 tx_valid_next;
  logic [NUM_REQ-1:0]   req_ready_q;
  logic [NUM_REQ-1:0]   req_ready_next;
  logic                 err_q;
  logic                 err_next;
  logic                 busy_q;

  logic [IDW-1:0]       winner;
  logic                 found;
  int                   idx;
  logic [IDW-1:0]       ptr_after;
  logic [NUM_REQ-1:0]   ready_onehot;
  logic [7:0]           sel_data;
  logic                 wd_expired;

  // Round-robin scan: the first valid requester starting at rr_ptr and
  // wrapping modulo NUM_REQ wins.
  always_comb begin
    winner = rr_ptr;
    found  = 1'b0;
    idx    = 0;
    for (int i = 0; i < NUM_REQ; i++) begin
      idx = int'(rr_ptr) + i;
      if (idx >= NUM_REQ) begin
        idx = idx - NUM_REQ;
      end
      if (!found && bus.req_valid[idx]) begin
        winner = IDW'(idx);
        found  = 1'b1;
      end
    end
  end

  // Helpers derived from the stored winner: pointer after it, its one-hot
  // accept vector and its data lane.
  always_comb begin
    ptr_after = (grant_id_q == IDW'(NUM_REQ - 1)) ? '0 : grant_id_q + 1'b1;
    for (int i = 0; i < NUM_REQ; i++) begin
      ready_onehot[i] = (grant_id_q == IDW'(i));
    end
    sel_data   = bus.req_data[8*int'(grant_id_q) +: 8];
    wd_expired = (wd_cnt == WD_LAST);
  end

  // Next-state and registered-output logic. tx_valid, req_ready and
  // err_timeout are pulses, so they default low every cycle; tx_data and
  // grant_id hold their values until explicitly reloaded.
  always_comb begin
    state_next     = state;
    rr_ptr_next    = rr_ptr;
    grant_id_next  = grant_id_q;
    wd_next        = '0;
    tx_data_next   = tx_data_q;
    tx_valid_next  = 1'b0;
    req_ready_next = '0;
    err_next       = 1'b0;

    case (state)
      IDLE: begin
        if (found) begin
          grant_id_next = winner;
          state_next    = LOAD;
        end
      end

      LOAD: begin
`ifdef UART_ARB_ID_HDR_EN
        tx_data_next  = {4'hA, 4'(grant_id_q)};
        tx_valid_next = 1'b1;
        state_next    = HWAIT;
`else
        tx_data_next   = sel_data;
        tx_valid_next  = 1'b1;
        req_ready_next = ready_onehot;
        rr_ptr_next    = ptr_after;
        state_next     = WAIT;
`endif
      end

`ifdef UART_ARB_ID_HDR_EN
      // Header frame: a timeout here drops the whole grant, so the
      // requester keeps its byte and rr_ptr is left unchanged.
      HWAIT: begin
        if (bus.tx_done) begin
          state_next = HGUARD;
        end else if (wd_expired) begin
          err_next   = 1'b1;
          state_next = IDLE;
        end else begin
          wd_next = wd_cnt + 1'b1;
        end
      end

      HGUARD: begin
        state_next = DLOAD;
      end

      DLOAD: begin
        tx_data_next   = sel_data;
        tx_valid_next  = 1'b1;
        req_ready_next = ready_onehot;
        rr_ptr_next    = ptr_after;
        state_next     = WAIT;
      end
`endif

      // tx_done is checked before the watchdog so a completion arriving on
      // the final allowed cycle is not reported as an error.
      WAIT: begin
        if (bus.tx_done) begin
          state_next = GUARD;
        end else if (wd_expired) begin
          err_next   = 1'b1;
          state_next = IDLE;
        end else begin
          wd_next = wd_cnt + 1'b1;
        end
      end

      GUARD: begin
        state_next = IDLE;
      end

      default: begin
        state_next = IDLE;
      end
    endcase
  end

  // State and output registers. busy follows the state being entered so it
  // is registered yet still matches the state on every cycle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= IDLE;
      rr_ptr      <= '0;
      grant_id_q  <= '0;
      wd_cnt      <= '0;
      tx_data_q   <= 8'h00;
      tx_valid_q  <= 1'b0;
      req_ready_q <= '0;
      err_q       <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      state       <= state_next;
      rr_ptr      <= rr_ptr_next;
      grant_id_q  <= grant_id_next;
      wd_cnt      <= wd_next;
      tx_data_q   <= tx_data_next;
      tx_valid_q  <= tx_valid_next;
      req_ready_q <= req_ready_next;
      err_q       <= err_next;
      busy_q      <= (state_next != IDLE);
    end
  end

  assign bus.req_ready   = req_ready_q;
  assign bus.grant_id    = grant_id_q;
  assign bus.busy        = busy_q;
  assign bus.err_timeout = err_q;
  assign bus.tx_data     = tx_data_q;
  assign bus.tx_valid    = tx_valid_q;

endmodule
